// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU definitions: control codes, default datapath widths
//             and the held-operation record used by the ID/EX stage.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // One decoded op as held in a pipeline slot. opb is operand B already
  // resolved (immediate or rs2 data) at capture time.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   rs1_val;
    logic [XLEN_DEF-1:0]   opb;
    logic [XLEN_DEF-1:0]   rs2_val;
    logic [3:0]            alu_ctrl;
    logic [REG_AW_DEF-1:0] rs1;
    logic [REG_AW_DEF-1:0] rs2;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic                  alu_src;
  } ex_op_t;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : Per-operand forwarding select. EX/MEM wins over MEM/WB; x0 is
//             never forwarded; otherwise the stored register value passes.
//  Ports    : src              - source register index of the operand
//             stored           - value captured from the register file
//             ex_mem_*         - destination / write enable / result in EX/MEM
//             mem_wb_*         - destination / write enable / result in MEM/WB
//             fwd_val          - selected operand value
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   stored,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  input  logic [XLEN-1:0]   mem_wb_result,
  output logic [XLEN-1:0]   fwd_val
);

  logic w_src_nz;
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_src_nz = (src != '0);
  assign w_ex_hit = ex_mem_reg_write && (ex_mem_rd == src) && w_src_nz;
  assign w_wb_hit = mem_wb_reg_write && (mem_wb_rd == src) && w_src_nz;

  // The younger producer (EX/MEM) holds the newest value of the register.
  assign fwd_val = w_ex_hit ? ex_mem_result :
                   w_wb_hit ? mem_wb_result : stored;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register in front of the ALU. Decoded ops are
//             held in a two-entry skid buffer (main + skid slot) with
//             valid/ready handshakes on both sides; operand B is resolved at
//             capture. Build option ID_EX_FWD_EN adds combinational
//             EX/MEM and MEM/WB forwarding onto the main slot's operands.
//  Ports    : clk, rst                   - clock, synchronous active-high reset
//             in_valid / in_ready        - upstream handshake
//             in_rs1_val .. in_reg_write - decoded op fields
//             flush                      - drop every held op
//             ex_mem_* / mem_wb_*        - forwarding sources
//             out_valid / out_ready      - downstream handshake
//             alu_in1, alu_in2, alu_ctrl - ALU operands/control (0 if invalid)
//             out_rd, out_reg_write      - destination metadata
//             out_rs2_val                - rs2 data for stores
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import alu_pkg::*;
#(
  // The held-op record comes from alu_pkg, so these must track its defaults.
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_alu_src,
  input  logic [3:0]        in_alu_ctrl,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  input  logic [XLEN-1:0]   mem_wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [3:0]        alu_ctrl,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic [XLEN-1:0]   out_rs2_val
);

  ex_op_t          r_main;
  ex_op_t          r_skid;
  ex_op_t          w_in_op;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            w_in_fire;
  logic            w_out_fire;
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  logic [XLEN-1:0] w_rs2_fwd;

  // Ready depends only on skid occupancy, so out_ready never reaches it.
  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_main_valid;
  assign w_in_fire  = in_valid & ~r_skid_valid;
  assign w_out_fire = r_main_valid & out_ready;

  always_comb begin
    w_in_op           = '0;
    w_in_op.rs1_val   = in_rs1_val;
    w_in_op.opb       = in_alu_src ? in_imm : in_rs2_val;
    w_in_op.rs2_val   = in_rs2_val;
    w_in_op.alu_ctrl  = in_alu_ctrl;
    w_in_op.rs1       = in_rs1;
    w_in_op.rs2       = in_rs2;
    w_in_op.rd        = in_rd;
    w_in_op.reg_write = in_reg_write;
    w_in_op.alu_src   = in_alu_src;
  end

  // Occupancy. The skid slot is only ever full while main is full, so a
  // full skid drains into main before anything new is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (out_ready) r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      r_main_valid <= w_in_fire;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (r_skid_valid) begin
      if (out_ready) r_main <= r_skid;
    end else if (!r_main_valid || w_out_fire) begin
      if (w_in_fire) r_main <= w_in_op;
    end else if (w_in_fire) begin
      r_skid <= w_in_op;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src              (r_main.rs1),
    .stored           (r_main.rs1_val),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_result    (mem_wb_result),
    .fwd_val          (w_in1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src              (r_main.rs2),
    .stored           (r_main.rs2_val),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_result    (mem_wb_result),
    .fwd_val          (w_rs2_fwd)
  );

  // An immediate operand B is never overridden by forwarding.
  assign w_in2 = r_main.alu_src ? r_main.opb : w_rs2_fwd;
`else
  assign w_in1     = r_main.rs1_val;
  assign w_in2     = r_main.opb;
  assign w_rs2_fwd = r_main.rs2_val;

  // Forwarding inputs and source indices are intentionally ignored here.
  logic w_fwd_unused;
  assign w_fwd_unused = ^{ex_mem_rd, ex_mem_reg_write, ex_mem_result,
                          mem_wb_rd, mem_wb_reg_write, mem_wb_result,
                          r_main.rs1, r_main.rs2, r_main.alu_src};
`endif

  assign alu_in1       = r_main_valid ? w_in1 : '0;
  assign alu_in2       = r_main_valid ? w_in2 : '0;
  assign alu_ctrl      = r_main_valid ? r_main.alu_ctrl : 4'b0000;
  assign out_reg_write = r_main_valid & r_main.reg_write;
  assign out_rd        = r_main.rd;
  assign out_rs2_val   = w_rs2_fwd;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU.
- Registers decoded operations from the decode stage through a 2-entry skid buffer with valid/ready handshakes.
- Resolves operand B: register or immediate.
- Optionally forwards results from EX/MEM and MEM/WB, then drives ALU in1/in2/alu_ctrl plus metadata for the EX/MEM register.

Parameters:
XLEN, 32, datapath width; ALU operand and result width.
REG_AW, 5, register index width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  decode presents an op.
in_ready  output  1  stage can accept an op.
in_rs1_val  input  XLEN  rs1 read data.
in_rs2_val  input  XLEN  rs2 read data.
in_imm  input  XLEN  sign-extended immediate.
in_alu_src  input  1  1 = operand B is in_imm.
in_alu_ctrl  input  4  ALU op code.
in_rs1, in_rs2, in_rd  input  REG_AW each  register indices.
in_reg_write  input  1  op writes rd.
flush  input  1  kill all held ops (branch redirect).
ex_mem_rd  input  REG_AW  destination of the op in EX/MEM.
ex_mem_reg_write  input  1  EX/MEM op writes.
ex_mem_result  input  XLEN  EX/MEM ALU result.
mem_wb_rd  input  REG_AW  destination of the op in MEM/WB.
mem_wb_reg_write  input  1  MEM/WB op writes.
mem_wb_result  input  XLEN  writeback data.
out_valid  output  1  ALU inputs valid.
out_ready  input  1  downstream accepts.
alu_in1  output  XLEN  ALU in1.
alu_in2  output  XLEN  ALU in2.
alu_ctrl  output  4  ALU control.
out_rd  output  REG_AW  destination index.
out_reg_write  output  1  gated: 0 whenever out_valid = 0.
out_rs2_val  output  XLEN  forwarded rs2, for stores.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Storage:
  - main slot: drives outputs.
  - skid slot: holds one extra op.
  - Each slot has its own valid bit.
- in_ready = !skid_valid. It is a registered bit, with no combinational path from out_ready.
- Transfer occurs on valid && ready at the same clock edge, on both sides.
- Per-edge priority:
  1. rst
  2. flush
  3. handshake updates
- rst: both valid bits 0, so out_valid = 0 and in_ready = 1.
  - Data registers are don't-care.
  - alu_ctrl, alu_in1 and alu_in2 read 0 while out_valid = 0; drive 0 combinationally when invalid.
- flush:
  - Clears both valid bits on the next edge.
  - An input handshake in the same cycle is discarded.
  - in_ready = 1 the following cycle.
- Main empty, input accept: op goes to main. out_valid = 1 the next cycle, giving 1-cycle latency.
- Main full, out_ready = 1, input accept: new op replaces main.
- Main full, out_ready = 0, input accept: op goes to skid; in_ready drops the next cycle.
- Main full with skid full, out_ready = 1: skid moves to main, skid empties.
  - Input is not accepted that cycle because in_ready = 0.
- Ordering is strictly FIFO, with no drop or duplication under any valid/ready pattern.
- Operand B = in_alu_src ? imm : rs2_val. This is selected at capture and stored.
- Operand A = stored rs1_val.
- No arithmetic is performed in this block. Widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding is applied combinationally to the main slot's operands.
  - Priority per source register r (rs1 → alu_in1; rs2 → out_rs2_val, and alu_in2 when alu_src = 0):
    1. ex_mem_reg_write && ex_mem_rd == r && r != 0 → ex_mem_result.
    2. Else mem_wb_reg_write && mem_wb_rd == r && r != 0 → mem_wb_result.
    3. Else the stored value.
  - Immediate operand B is never overridden.
- Undefined:
  - Stored values drive the outputs directly.
  - Forwarding ports are present but ignored.
  - Hazards are the responsibility of upstream stall logic.

Decomposition:
- Shared package `alu_pkg`:
  - ALU control constants: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110.
  - Struct ex_op_t: rs1_val, opb, rs2_val, alu_ctrl, rs1, rs2, rd, reg_write, alu_src.
  - XLEN/REG_AW defaults.
- One sub-module: `fwd_mux`, the per-operand 3-way priority select. It is instantiated twice.

Test Plan:
- Reset then idle: after rst high for 2 cycles, expect out_valid = 0, in_ready = 1, alu_ctrl = 0, out_reg_write = 0.
- Single op with no backpressure:
  - Stimulus: rs1_val = 5, imm = 7, alu_src = 1, ctrl = ADD.
  - Expect next cycle: alu_in1 = 5, alu_in2 = 7, alu_ctrl = 4'b0010, out_valid = 1.
- Backpressure:
  - Stimulus: send ops A, B, C back-to-back with out_ready = 0.
  - Expect A and B accepted, in_ready = 0 on the third cycle, C held upstream.
  - Raise out_ready: outputs in order A, B, C with none lost.
- Flush with a full skid buffer:
  - Stimulus: assert flush while ops are held.
  - Expect out_valid = 0 the next cycle and in_ready = 1.
  - An op presented with flush is not emitted.
- Forwarding priority (ID_EX_FWD_EN defined):
  - Stimulus: rs1 = 3, ex_mem_rd = 3 with result 0xAA, mem_wb_rd = 3 with result 0xBB.
  - Expect alu_in1 = 0xAA; with ex_mem_reg_write = 0, expect 0xBB; with rs1 = 0, expect the stored value.
- Forwarding disabled (ID_EX_FWD_EN undefined): same stimulus → alu_in1 equals the stored rs1_val.
